// File: rtl/uart_transmitter.sv
// uart_transmitter: serializing half of the 8-bit UART.
// Accepts bytes over valid/ready into a one-entry holding register and
// shifts them out LSB-first as start, 8 data bits, optional parity and
// STOP_BITS stop bits, one bit per shared baud_tick.
//
// Parameters:
//   STOP_BITS  - stop bits per frame, 1 or 2
//   PARITY_ODD - 0: even parity, 1: odd parity (parity builds only)
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   baud_tick  - one-clk pulse per bit period
//   tx_data    - byte to send, sampled on handshake
//   tx_valid   - tx_data is valid
//   tx_ready   - holding register empty (registered)
//   tx_serial  - registered serial line, idles high
//   tx_busy    - FSM not idle or holding register full
//   tx_done    - one-clk pulse when the last stop bit ends
//
// Build option:
//   UART_TX_PARITY_EN - when defined, a parity bit follows data bit 7.

module uart_transmitter #(
    parameter int unsigned STOP_BITS  = 1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    // Any value other than 2 is treated as a single stop bit.
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       tx_serial_q, tx_serial_d;
    logic       tx_ready_q, tx_ready_d;
    logic       tx_done_q, tx_done_d;

`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`else
    logic       unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    logic       accept;
    logic       load;

    assign accept = tx_valid && tx_ready_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        stop_cnt_d  = stop_cnt_q;
        tx_serial_d = tx_serial_q;
        tx_done_d   = 1'b0;
        load        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (baud_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end
                end
                S_START: begin
                    state_d     = S_DATA;
                    tx_serial_d = shift_q[0];
                    cnt_d       = 3'd0;
                end
                S_DATA: begin
                    if (cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d     = S_PARITY;
                        tx_serial_d = par_q;
`else
                        state_d     = S_STOP;
                        tx_serial_d = 1'b1;
                        stop_cnt_d  = 1'b0;
`endif
                    end else begin
                        // Bit 0 of the shifted value is the next bit out.
                        shift_d     = {1'b0, shift_q[7:1]};
                        cnt_d       = cnt_q + 3'd1;
                        tx_serial_d = shift_q[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    state_d     = S_STOP;
                    tx_serial_d = 1'b1;
                    stop_cnt_d  = 1'b0;
                end
`endif
                S_STOP: begin
                    if (stop_cnt_q == STOP_LAST) begin
                        tx_done_d = 1'b1;
                        if (hold_full_q) begin
                            // Chain straight into the next frame.
                            load = 1'b1;
                        end else begin
                            state_d     = S_IDLE;
                            tx_serial_d = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    tx_serial_d = 1'b1;
                end
            endcase
        end

        if (load) begin
            state_d     = S_START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_serial_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d       = (^hold_q) ^ PARITY_ODD;
`endif
        end

        // Ready drops on the handshake edge and only returns one clk
        // after the holding register has been emptied.
        tx_ready_d = accept ? 1'b0 : !hold_full_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            cnt_q       <= 3'd0;
            stop_cnt_q  <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_serial_q <= tx_serial_d;
            tx_ready_q  <= tx_ready_d;
            tx_done_q   <= tx_done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign tx_ready  = tx_ready_q;
    assign tx_serial = tx_serial_q;
    assign tx_done   = tx_done_q;
    assign tx_busy   = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serializing half of the 8-bit UART. Accepts bytes over a valid/ready handshake into a one-entry holding register and shifts them out on `tx_serial` as start, 8 data bits LSB-first, optional parity, and stop bit(s). Each bit is paced by the same shared `baud_tick` (one pulse per bit period) that the UART receiver samples on. The one-entry buffer lets back-to-back frames go out with no idle gap.

## Interface
- `STOP_BITS`, default 1: number of stop bits per frame; legal values are 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Only used when parity is compiled in.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `baud_tick` in 1: one-`clk` pulse per bit period; bit boundaries occur only on this pulse.
- `tx_data` in 8: byte to send; sampled on handshake.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: holding register is empty; a handshake occurs when `tx_valid && tx_ready` on a `clk` edge.
- `tx_serial` out 1: serial line; registered; idles high.
- `tx_busy` out 1: high when the FSM is not IDLE or the holding register is full.
- `tx_done` out 1: one-`clk` pulse at the `baud_tick` that ends the last stop bit.

## Operation
- Reset values: `tx_serial`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, FSM=IDLE, holding register empty, shift register = 0x00, bit counter = 0.
- Handshake: `tx_data` is copied to the holding register and `hold_full` sets. `tx_ready` = !`hold_full`, driven from a register, so at most one byte is accepted per frame slot.
- FSM states: IDLE, START, DATA, PARITY, STOP. Transitions happen only on a cycle where `baud_tick`=1.
  - IDLE → START: on `baud_tick` with `hold_full`=1. The holding register moves to the shift register, `hold_full` clears, and `tx_serial` goes to 0.
  - START → DATA: on `baud_tick`. `tx_serial` = `shift[0]`, bit counter = 0.
  - DATA: on each `baud_tick`, shift right and increment the counter. After bit 7, go to PARITY (macro defined) or STOP (macro undefined).
  - PARITY → STOP: on `baud_tick`. `tx_serial` = 1.
  - STOP: lasts `STOP_BITS` bit periods with `tx_serial`=1. At the final `baud_tick`, pulse `tx_done`. If `hold_full`, go directly to START, loading the next byte as in IDLE → START; otherwise go to IDLE.
- Parity bit = XOR of the 8 data bits, XOR `PARITY_ODD`. It is computed from the byte when it is loaded into the shift register.
- A `baud_tick` arriving in IDLE with the holding register empty does nothing.

## Timing
- Every bit, including the start bit, lasts exactly one `baud_tick` interval. `tx_serial` changes on the `clk` edge where `baud_tick`=1.
- Frame latency: the start bit begins at the first `baud_tick` strictly after the handshake edge. A handshake and a `baud_tick` on the same edge does not start the frame; it starts on the next `baud_tick`.
- Frame length: 10 bit periods for 8N1; +1 with parity; +1 for `STOP_BITS`=2.
- Back-to-back: `tx_ready` rises one `clk` after the IDLE/STOP → START transfer. A byte accepted any time before the final stop `baud_tick` follows with zero idle bits.
- `tx_valid` with `tx_ready`=0: no handshake; `tx_data` may change freely; nothing is lost or duplicated.
- `rst` mid-frame: outputs return to reset values immediately. The holding byte is discarded and the line goes high (a truncated frame is acceptable).
- `tx_done` and the START load occur on the same edge during back-to-back operation.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state is present and one parity bit is sent between data bit 7 and the stop bit(s).
  - Undefined: the PARITY state and parity logic are removed; DATA goes directly to STOP; the frame is 8N1 (or 8N2).
- `PARITY_ODD` is ignored when the macro is undefined.

## Test plan
- 8N1, send 0xA5, macro undefined → `tx_serial` over 10 ticks = 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses once. `tx_busy` falls after the stop bit.
- Macro defined, `PARITY_ODD`=0, send 0xA5 then 0x07 → parity bits are 0 and 1 respectively. `PARITY_ODD`=1 inverts both.
- Back-to-back 0x00 then 0xFF, with 0xFF presented as soon as `tx_ready` rises → 20 contiguous bit periods, no idle high between frames, two `tx_done` pulses.
- `tx_valid` held with 3 bytes queued, `tx_ready` low → exactly 3 frames, in order, no drops.
- `STOP_BITS`=2, send 0x3C → 11-bit frame with two high stop periods; `tx_done` pulses on the 11th tick.
- Assert `rst` during DATA bit 4 → `tx_serial`=1, `tx_ready`=1, `tx_busy`=0 within the same cycle. The next byte sent transmits correctly.
